aurora_tx_rr_arbiter: RTL and testbench

- Shares one Aurora 8b10b framing TX channel (32-bit AXI-Stream, user_clk domain) between NUM_SRC packet sources.
- Uses packet-level round-robin arbitration. Each forwarded packet is prefixed with one header beat carrying the source index, so the far-end RX demux can route it.
- Polices oversize packets and link loss, and keeps sent and dropped packet counters.
- Sits between the per-channel test/user traffic generators and the s_axi_tx_* port of the aurora_8b10b wrapper, one instance per SFP channel.

---
 rtl/aurora_tx_rr_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_aurora_tx_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_rr_arbiter.sv
// rtl/aurora_tx_rr_arbiter.sv - packet-level round-robin arbiter feeding one Aurora 8b10b TX channel
// Each granted packet is preceded by a header beat tagging its source index for the far-end demux.
module aurora_tx_rr_arbiter #(
    parameter int          NUM_SRC    = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          MAX_BEATS  = 256,
    parameter logic [15:0] HDR_MAGIC  = 16'hA55A
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_i,
    input  logic                            channel_up_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata_i,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tkeep_i,
    input  logic [NUM_SRC-1:0]              s_tlast_i,
    input  logic [NUM_SRC-1:0]              s_tvalid_i,
    output logic [NUM_SRC-1:0]              s_tready_o,
    output logic [DATA_WIDTH-1:0]           m_axi_tx_tdata_o,
    output logic [DATA_WIDTH/8-1:0]         m_axi_tx_tkeep_o,
    output logic                            m_axi_tx_tlast_o,
    output logic                            m_axi_tx_tvalid_o,
    input  logic                            m_axi_tx_tready_i,
    output logic [NUM_SRC-1:0]              grant_o,
    output logic                            err_oversize_o,
    output logic                            err_link_down_o,
    output logic [31:0]                     pkt_cnt_o,
    output logic [15:0]                     drop_cnt_o
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BCNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [IDX_W:0]       NUM_SRC_W  = (IDX_W+1)'(NUM_SRC);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_SRC - 1);
    localparam logic [BCNT_W-1:0]    BEAT_LIMIT = BCNT_W'(MAX_BEATS - 1);
    localparam logic [NUM_SRC-1:0]   GRANT_LSB  = NUM_SRC'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]      r_grant_idx;
    logic [IDX_W-1:0]      r_last_grant;
    logic [NUM_SRC-1:0]    r_grant;
    logic [BCNT_W-1:0]     r_beat_cnt;
    logic [31:0]           r_pkt_cnt;
    logic [15:0]           r_drop_cnt;
    logic                  r_err_oversize;
    logic                  r_err_link_down;

    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_found;
    logic [DATA_WIDTH-1:0] w_src_tdata;
    logic [KEEP_W-1:0]     w_src_tkeep;
    logic                  w_src_tvalid;
    logic                  w_src_tlast;
    logic [DATA_WIDTH-1:0] w_hdr;
    logic                  w_beat_max;
    logic                  w_hs;
    logic                  w_link_drop;
    logic                  w_pkt_done;
    logic                  w_oversize;
    logic                  w_drain_done;

    // Scan starts one past the previous owner so a busy source cannot win twice while others wait.
    always_comb begin
        logic [IDX_W:0] v_cand;
        v_cand      = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            v_cand = {1'b0, r_last_grant} + (IDX_W+1)'(i);
            if (v_cand >= NUM_SRC_W) begin
                v_cand = v_cand - NUM_SRC_W;
            end
            if (!w_win_found && s_tvalid_i[v_cand[IDX_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_cand[IDX_W-1:0];
            end
        end
    end

    assign w_src_tdata  = s_tdata_i[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_src_tkeep  = s_tkeep_i[r_grant_idx*KEEP_W +: KEEP_W];
    assign w_src_tvalid = s_tvalid_i[r_grant_idx];
    assign w_src_tlast  = s_tlast_i[r_grant_idx];
    assign w_hdr        = DATA_WIDTH'({HDR_MAGIC, 8'(r_grant_idx), 8'h00});
    assign w_beat_max   = (r_beat_cnt == BEAT_LIMIT);

    assign w_hs         = m_axi_tx_tvalid_o & m_axi_tx_tready_i;
    assign w_link_drop  = ((r_state == ST_HDR) || (r_state == ST_DATA)) && !channel_up_i;
    assign w_pkt_done   = (r_state == ST_DATA) && w_hs && w_src_tlast;
    assign w_oversize   = (r_state == ST_DATA) && w_hs && w_beat_max && !w_src_tlast;
    assign w_drain_done = (r_state == ST_DRAIN) && w_src_tvalid && w_src_tlast;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (channel_up_i && w_win_found) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_link_drop) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_hs) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_link_drop) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_pkt_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_oversize) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Link loss masks tvalid/tready in the same cycle so no beat slips through after channel_up falls.
    always_comb begin
        m_axi_tx_tdata_o  = '0;
        m_axi_tx_tkeep_o  = '0;
        m_axi_tx_tlast_o  = 1'b0;
        m_axi_tx_tvalid_o = 1'b0;
        s_tready_o        = '0;
        case (r_state)
            ST_HDR: begin
                m_axi_tx_tdata_o  = w_hdr;
                m_axi_tx_tkeep_o  = '1;
                m_axi_tx_tvalid_o = channel_up_i;
            end
            ST_DATA: begin
                m_axi_tx_tdata_o  = w_src_tdata;
                m_axi_tx_tkeep_o  = w_src_tkeep;
                m_axi_tx_tlast_o  = w_src_tlast | w_beat_max;
                m_axi_tx_tvalid_o = w_src_tvalid & channel_up_i;
                s_tready_o[r_grant_idx] = m_axi_tx_tready_i & channel_up_i;
            end
            ST_DRAIN: begin
                s_tready_o[r_grant_idx] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant_idx     <= '0;
            r_last_grant    <= LAST_IDX;
            r_grant         <= '0;
            r_beat_cnt      <= '0;
            r_pkt_cnt       <= '0;
            r_drop_cnt      <= '0;
            r_err_oversize  <= 1'b0;
            r_err_link_down <= 1'b0;
        end else begin
            r_err_oversize  <= w_oversize;
            r_err_link_down <= w_link_drop;

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_HDR)) begin
                r_grant_idx <= w_win_idx;
                r_grant     <= GRANT_LSB << w_win_idx;
            end else if (w_pkt_done || w_drain_done) begin
                r_last_grant <= r_grant_idx;
                r_grant      <= '0;
            end

            if ((r_state == ST_HDR) && w_hs) begin
                r_beat_cnt <= '0;
            end else if ((r_state == ST_DATA) && w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end

            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end

            if ((w_oversize || w_link_drop) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign grant_o         = r_grant;
    assign err_oversize_o  = r_err_oversize;
    assign err_link_down_o = r_err_link_down;
    assign pkt_cnt_o       = r_pkt_cnt;
    assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_aurora_tx_rr_arbiter.sv
// tb/tb_aurora_tx_rr_arbiter.sv - directed bench for aurora_tx_rr_arbiter
module tb_aurora_tx_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              channel_up;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS*KW-1:0]  s_tkeep;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [NS-1:0]     grant;
    logic              err_ov;
    logic              err_ld;
    logic [31:0]       pkt_cnt;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    aurora_tx_rr_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (256),
        .HDR_MAGIC  (16'hA55A)
    ) dut (
        .sys_clk_i         (clk),
        .rst_i             (rst),
        .channel_up_i      (channel_up),
        .s_tdata_i         (s_tdata),
        .s_tkeep_i         (s_tkeep),
        .s_tlast_i         (s_tlast),
        .s_tvalid_i        (s_tvalid),
        .s_tready_o        (s_tready),
        .m_axi_tx_tdata_o  (m_tdata),
        .m_axi_tx_tkeep_o  (m_tkeep),
        .m_axi_tx_tlast_o  (m_tlast),
        .m_axi_tx_tvalid_o (m_tvalid),
        .m_axi_tx_tready_i (m_tready),
        .grant_o           (grant),
        .err_oversize_o    (err_ov),
        .err_link_down_o   (err_ld),
        .pkt_cnt_o         (pkt_cnt),
        .drop_cnt_o        (drop_cnt)
    );

    int          src_rem  [NS];
    int          src_len  [NS];
    int          src_beat [NS];
    int          src_pkt  [NS];
    int          src_cons [NS];
    logic [31:0] cap_data [$];
    bit          cap_last [$];
    int          cap_cyc  [$];
    int          cap_hdr  [$];
    int          cyc, frame_dcnt, ov_cnt, ld_cnt, mirror_err, mirror_n;
    bit          in_data, rdy_rand, rdy_fixed;
    int          n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int oh2idx(input logic [NS-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NS; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            s_tvalid[k]          = (src_rem[k] > 0);
            s_tdata[k*DW +: DW]  = {8'(k), 8'(src_pkt[k]), 16'(src_beat[k] + 1)};
            s_tlast[k]           = (src_beat[k] == src_len[k] - 1);
            s_tkeep[k*KW +: KW]  = '1;
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    endtask

    task automatic sample();
        logic [NS-1:0] exp_rdy;
        cyc++;
        if (grant == '0) in_data = 1'b0;
        if (in_data && channel_up) begin
            exp_rdy = '0;
            if (m_tready) exp_rdy[oh2idx(grant)] = 1'b1;
            mirror_n++;
            if (s_tready !== exp_rdy) mirror_err++;
        end
        if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_last.push_back(m_tlast);
            cap_cyc.push_back(cyc);
            if (m_tdata[31:16] == 16'hA55A) begin
                cap_hdr.push_back(int'(m_tdata[15:8]));
                in_data    = 1'b1;
                frame_dcnt = 0;
            end else begin
                frame_dcnt++;
                if (m_tlast) in_data = 1'b0;
            end
        end
        if (err_ov) ov_cnt++;
        if (err_ld) ld_cnt++;
        for (int k = 0; k < NS; k++) begin
            if (s_tvalid[k] && s_tready[k]) begin
                src_cons[k]++;
                src_beat[k]++;
                if (src_beat[k] == src_len[k]) begin
                    src_beat[k] = 0;
                    src_pkt[k]++;
                    src_rem[k]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic wait_pkt(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while ((pkt_cnt != 32'(target)) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq(tag, pkt_cnt, 64'(target));
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
        cap_hdr.delete();
    endtask

    initial begin
        int base, p, cons0, fwd0, ov0, ld0, busy, n;
        n_checks = 0; n_pass = 0; cyc = 0; frame_dcnt = 0;
        ov_cnt = 0; ld_cnt = 0; mirror_err = 0; mirror_n = 0;
        in_data = 1'b0; rdy_rand = 1'b0; rdy_fixed = 1'b1;
        for (int k = 0; k < NS; k++) begin
            src_rem[k] = 0; src_len[k] = 1; src_beat[k] = 0; src_pkt[k] = 0; src_cons[k] = 0;
        end
        rst = 1'b1;
        channel_up = 1'b1;
        drive();
        repeat (3) tick();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_tready", s_tready, 0);
        check_eq("rst_pkt_cnt", pkt_cnt, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        tick();

        // all four sources, one 3-beat packet each
        clear_cap();
        for (int k = 0; k < NS; k++) begin src_rem[k] = 1; src_len[k] = 3; end
        wait_pkt(4, 100, "t1_pkt_cnt");
        check_eq("t1_nbeats", cap_data.size(), 16);
        for (int k = 0; k < NS; k++) begin
            check_eq($sformatf("t1_hdr%0d", k), cap_data[4*k], 64'(32'hA55A0000 | (k << 8)));
            for (int j = 1; j <= 3; j++) begin
                check_eq($sformatf("t1_d%0d_%0d", k, j), cap_data[4*k+j], 64'({8'(k), 8'h00, 16'(j)}));
                check_eq($sformatf("t1_last%0d_%0d", k, j), cap_last[4*k+j], (j == 3) ? 1 : 0);
            end
            if (k < NS - 1)
                check_eq($sformatf("t1_gap%0d", k), cap_cyc[4*k+4] - cap_cyc[4*k+3], 2);
        end

        // continuous source 1 against a single request from source 2
        clear_cap();
        base = int'(pkt_cnt);
        p = src_cons[2];
        src_rem[1] = 5; src_len[1] = 2;
        src_rem[2] = 1; src_len[2] = 2;
        wait_pkt(base + 6, 200, "t2_pkt_cnt");
        check_eq("t2_g0", cap_hdr[0], 1);
        check_eq("t2_g1", cap_hdr[1], 2);
        check_eq("t2_g2", cap_hdr[2], 1);
        check_eq("t2_g3", cap_hdr[3], 1);
        check_eq("t2_src2_served", src_cons[2] - p, 2);

        // 10-beat packet under random backpressure
        clear_cap();
        base = int'(pkt_cnt);
        p = src_pkt[3];
        mirror_err = 0; mirror_n = 0;
        rdy_rand = 1'b1;
        src_rem[3] = 1; src_len[3] = 10;
        wait_pkt(base + 1, 400, "t3_pkt_cnt");
        rdy_rand = 1'b0; rdy_fixed = 1'b1;
        check_eq("t3_nbeats", cap_data.size(), 11);
        check_eq("t3_hdr", cap_data[0], 32'hA55A0300);
        for (int i = 1; i <= 10; i++) begin
            check_eq($sformatf("t3_d%0d", i), cap_data[i], 64'({8'd3, 8'(p), 16'(i)}));
            check_eq($sformatf("t3_last%0d", i), cap_last[i], (i == 10) ? 1 : 0);
        end
        check_eq("t3_mirror_err", mirror_err, 0);
        check_eq("t3_mirror_seen", mirror_n >= 10, 1);

        // 300-beat packet truncated at 256, source 1 waiting behind it
        tick();
        clear_cap();
        base = int'(pkt_cnt);
        p = src_pkt[0];
        cons0 = src_cons[0];
        ov0 = ov_cnt; ld0 = ld_cnt;
        src_rem[0] = 1; src_len[0] = 300;
        src_rem[1] = 1; src_len[1] = 2;
        wait_pkt(base + 1, 800, "t4_pkt_cnt");
        check_eq("t4_nbeats", cap_data.size(), 260);
        check_eq("t4_b255_last", cap_last[255], 0);
        check_eq("t4_b256_last", cap_last[256], 1);
        check_eq("t4_b256_data", cap_data[256], 64'({8'd0, 8'(p), 16'd256}));
        check_eq("t4_next_hdr", cap_data[257], 32'hA55A0100);
        check_eq("t4_ov_pulses", ov_cnt - ov0, 1);
        check_eq("t4_ld_pulses", ld_cnt - ld0, 0);
        check_eq("t4_drop_cnt", drop_cnt, 1);
        fwd0 = 0;
        foreach (cap_data[i]) if (cap_data[i][31:16] != 16'hA55A && cap_data[i][31:24] == 8'd0) fwd0++;
        check_eq("t4_consumed", src_cons[0] - cons0, 300);
        check_eq("t4_drained", (src_cons[0] - cons0) - fwd0, 44);

        // link loss at data beat 5 of 20, source 3 waiting
        clear_cap();
        base = int'(pkt_cnt);
        p = src_cons[2];
        ov0 = ov_cnt; ld0 = ld_cnt;
        src_rem[2] = 1; src_len[2] = 20;
        src_rem[3] = 1; src_len[3] = 2;
        n = 0;
        while (!(in_data && frame_dcnt == 4) && n < 100) begin tick(); n++; end
        check_eq("t5_reach_beat5", n < 100, 1);
        channel_up = 1'b0;
        #1;
        check_eq("t5_tvalid_drop", m_tvalid, 0);
        check_eq("t5_tready_drop", s_tready, 0);
        n = 0;
        while ((src_cons[2] - p) < 20 && n < 100) begin tick(); n++; end
        check_eq("t5_consumed", src_cons[2] - p, 20);
        check_eq("t5_forwarded", frame_dcnt, 4);
        busy = 0;
        repeat (20) begin
            tick();
            if (grant != '0 || m_tvalid) busy++;
        end
        check_eq("t5_ld_pulses", ld_cnt - ld0, 1);
        check_eq("t5_ov_pulses", ov_cnt - ov0, 0);
        check_eq("t5_drop_cnt", drop_cnt, 2);
        check_eq("t5_idle_while_down", busy, 0);
        channel_up = 1'b1;
        wait_pkt(base + 1, 100, "t5_pkt_cnt");
        check_eq("t5_next_hdr", cap_hdr[cap_hdr.size()-1], 3);

        // reset in the middle of a packet from source 1 (last owner source 0)
        base = int'(pkt_cnt);
        src_rem[0] = 1; src_len[0] = 2;
        wait_pkt(base + 1, 100, "t6_pre_pkt");
        src_rem[1] = 1; src_len[1] = 10;
        n = 0;
        while (!(in_data && frame_dcnt == 3) && n < 100) begin tick(); n++; end
        check_eq("t6_reach_data", n < 100, 1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_grant", grant, 0);
        check_eq("t6_rst_tvalid", m_tvalid, 0);
        check_eq("t6_rst_tready", s_tready, 0);
        check_eq("t6_rst_pkt_cnt", pkt_cnt, 0);
        check_eq("t6_rst_drop_cnt", drop_cnt, 0);
        for (int k = 0; k < NS; k++) begin src_rem[k] = 0; src_beat[k] = 0; end
        repeat (2) tick();
        rst = 1'b0;
        clear_cap();
        src_rem[1] = 1; src_len[1] = 2;
        src_rem[0] = 1; src_len[0] = 2;
        wait_pkt(2, 100, "t6_pkt_cnt");
        check_eq("t6_first_grant", cap_hdr[0], 0);
        check_eq("t6_second_grant", cap_hdr[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
